// File: rtl/pusch_cp_pkg.sv
// Shared constants, types and arithmetic helpers for the PUSCH cyclic-prefix inserter.
package pusch_cp_pkg;

    localparam int unsigned IN_W      = 26;
    localparam int unsigned OUT_W     = 15;
    localparam int unsigned N_FFT     = 2048;
    localparam int unsigned ADDR_W    = $clog2(N_FFT);
    localparam int unsigned CP_LONG   = 160;
    localparam int unsigned CP_SHORT  = 144;
    localparam int unsigned CP_EXT    = 512;
    localparam int unsigned N_SYM     = 14;
    localparam int unsigned N_SYM_EXT = 12;
    localparam int unsigned SYM_W     = $clog2(N_SYM);
    localparam int unsigned LONG_SYM0 = 0;
    localparam int unsigned LONG_SYM1 = 7;
    localparam int unsigned SH        = IN_W - OUT_W;

    localparam logic signed [OUT_W:0] Q_MAX = (OUT_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [OUT_W:0] Q_MIN = ~Q_MAX;

    typedef enum logic [1:0] {RD_IDLE, RD_CP, RD_BODY} rd_state_t;

    typedef logic signed [IN_W-1:0]  in_samp_t;
    typedef logic signed [OUT_W-1:0] out_samp_t;

    typedef struct packed {
        in_samp_t re;
        in_samp_t im;
    } iq_in_t;

    // First address of the prefix window inside the stored symbol.
    function automatic logic [ADDR_W-1:0] cp_start_addr(input logic [SYM_W-1:0] sym,
                                                        input logic ext);
        int unsigned len;
        if (ext)
            len = CP_EXT;
        else if (sym == SYM_W'(LONG_SYM0) || sym == SYM_W'(LONG_SYM1))
            len = CP_LONG;
        else
            len = CP_SHORT;
        return ADDR_W'(N_FFT - len);
    endfunction

    // Round half up by SH bits, then clamp to the output range.
    function automatic out_samp_t round_sat(input in_samp_t x);
        logic signed [IN_W:0]  t;
        logic signed [OUT_W:0] q;
        t = {x[IN_W-1], x} + (IN_W+1)'(1 << (SH-1));
        q = (OUT_W+1)'(t >>> SH);
        if (q > Q_MAX)
            q = Q_MAX;
        else if (q < Q_MIN)
            q = Q_MIN;
        return OUT_W'(q);
    endfunction

endpackage

// File: rtl/cp_sym_buffer.sv
// Two-bank simple dual-port sample store with a one-cycle registered read.
module cp_sym_buffer #(
    parameter int unsigned W  = 52,
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter: double-buffers IFFT symbols, replays the prefix then the body.
// Optional extended-CP mode is compiled in with `define CP_EXT_EN.
module cp_inserter
    import pusch_cp_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
`ifdef CP_EXT_EN
    input  logic                    ext_cp,
`endif
    input  logic signed [IN_W-1:0]  in_r,
    input  logic signed [IN_W-1:0]  in_i,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_r,
    output logic signed [OUT_W-1:0] out_i,
    output logic                    out_valid,
    output logic                    sym_start,
    output logic                    slot_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_FFT - 1);

    rd_state_t         state;
    logic [1:0]        full;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] cp_start;
    logic [ADDR_W-1:0] next_start;
    logic [SYM_W-1:0]  sym_idx;
    logic [SYM_W-1:0]  sym_nxt;
    logic [SYM_W-1:0]  last_sym;
    logic              wr_fire;
    logic              wr_last;
    logic              body_last;
    logic              ext_sel;
    logic              rd_v1;
    logic              first1;
    logic              slot_last1;
    iq_in_t            wr_word;
    iq_in_t            rd_word;

    assign in_ready  = enable & ~full[wr_bank];
    assign wr_fire   = in_valid & in_ready;
    assign wr_last   = wr_fire && (wr_cnt == LAST_ADDR);
    assign body_last = (state == RD_BODY) && (rd_addr == LAST_ADDR);
    assign full_set  = {wr_last & wr_bank, wr_last & ~wr_bank};
    assign full_clr  = {body_last & rd_bank, body_last & ~rd_bank};
    assign wr_word   = '{re: in_r, im: in_i};

`ifdef CP_EXT_EN
    logic ext_mode;

    // Extended-CP choice is latched once per slot, when symbol 0 starts from idle.
    assign ext_sel = (state == RD_IDLE && sym_idx == '0) ? ext_cp : ext_mode;

    always_ff @(posedge clk) begin
        if (!reset)
            ext_mode <= 1'b0;
        else if (state == RD_IDLE && full[rd_bank] && sym_idx == '0)
            ext_mode <= ext_cp;
    end
`else
    assign ext_sel = 1'b0;
`endif

    assign last_sym   = ext_sel ? SYM_W'(N_SYM_EXT - 1) : SYM_W'(N_SYM - 1);
    assign sym_nxt    = (sym_idx == last_sym) ? '0 : sym_idx + SYM_W'(1);
    assign next_start = cp_start_addr((state == RD_BODY) ? sym_nxt : sym_idx, ext_sel);

    // Write side: fill the current bank, then hand it to the reader.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
        end else begin
            full <= (full | full_set) & ~full_clr;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                    wr_cnt  <= '0;
                end else begin
                    wr_cnt <= wr_cnt + ADDR_W'(1);
                end
            end
        end
    end

    cp_sym_buffer #(
        .W  ($bits(iq_in_t)),
        .AW (ADDR_W + 1)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr ({wr_bank, wr_cnt}),
        .wr_data (wr_word),
        .rd_en   (state != RD_IDLE),
        .rd_addr ({rd_bank, rd_addr}),
        .rd_data (rd_word)
    );

    // Read FSM; the stage-1 flags line up with the RAM read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= RD_IDLE;
            rd_bank    <= 1'b0;
            rd_addr    <= '0;
            cp_start   <= '0;
            sym_idx    <= '0;
            rd_v1      <= 1'b0;
            first1     <= 1'b0;
            slot_last1 <= 1'b0;
        end else begin
            rd_v1      <= (state != RD_IDLE);
            first1     <= (state == RD_CP) && (rd_addr == cp_start);
            slot_last1 <= body_last && (sym_idx == last_sym);
            case (state)
                RD_IDLE: begin
                    if (full[rd_bank]) begin
                        state    <= RD_CP;
                        rd_addr  <= next_start;
                        cp_start <= next_start;
                    end
                end
                RD_CP: begin
                    if (rd_addr == LAST_ADDR) begin
                        state   <= RD_BODY;
                        rd_addr <= '0;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                RD_BODY: begin
                    if (body_last) begin
                        rd_bank  <= ~rd_bank;
                        sym_idx  <= sym_nxt;
                        rd_addr  <= next_start;
                        cp_start <= next_start;
                        state    <= full[~rd_bank] ? RD_CP : RD_IDLE;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    // Output stage: rounding/saturation register, zero when idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_r     <= '0;
            out_i     <= '0;
            out_valid <= 1'b0;
            sym_start <= 1'b0;
            slot_done <= 1'b0;
        end else begin
            out_r     <= rd_v1 ? round_sat(rd_word.re) : '0;
            out_i     <= rd_v1 ? round_sat(rd_word.im) : '0;
            out_valid <= rd_v1;
            sym_start <= first1;
            slot_done <= slot_last1;
        end
    end

endmodule

// File: tb/tb_cp_inserter.sv
// Directed self-checking bench for cp_inserter: prefix lengths, ordering, rounding,
// flow control across banks, slot wrap and mid-symbol reset.
module tb_cp_inserter;
    import pusch_cp_pkg::*;

    logic                    clk      = 1'b0;
    logic                    reset    = 1'b0;
    logic                    enable   = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [IN_W-1:0]  in_r     = '0;
    logic signed [IN_W-1:0]  in_i     = '0;
    logic                    in_ready;
    logic signed [OUT_W-1:0] out_r;
    logic signed [OUT_W-1:0] out_i;
    logic                    out_valid;
    logic                    sym_start;
    logic                    slot_done;
`ifdef CP_EXT_EN
    logic                    ext_cp   = 1'b0;
`endif

    int n_cmp          = 0;
    int n_err          = 0;
    int slot_done_seen = 0;
    int rnd_obs [5];

    cp_inserter dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
`ifdef CP_EXT_EN
        .ext_cp    (ext_cp),
`endif
        .in_r      (in_r),
        .in_i      (in_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_valid (out_valid),
        .sym_start (sym_start),
        .slot_done (slot_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Mode 1 puts the rounding corner cases at the head of the body.
    function automatic int stim_r(input int mode, input int k);
        if (mode == 1) begin
            case (k)
                0: return 1023;
                1: return 1024;
                2: return -1025;
                3: return 33554431;
                4: return -33554432;
                default: ;
            endcase
        end
        return k << 11;
    endfunction

    function automatic int want_r(input int mode, input int k);
        if (mode == 1) begin
            case (k)
                0: return 0;
                1: return 1;
                2: return -1;
                3: return 16383;
                4: return -16384;
                default: ;
            endcase
        end
        return k;
    endfunction

    // Streams nsym symbols back to back; imag part tags the symbol number.
    task automatic wr_syms(input int s0, input int nsym, input int mode, input int pause_k,
                           output int stalls);
        int k          = 0;
        int budget     = 0;
        int pause_left = 6;
        int total      = nsym * 2048;
        stalls = 0;
        while (k < total && budget < total * 2 + 4000) begin
            @(negedge clk);
            budget++;
            in_valid = 1'b1;
            in_r     = IN_W'(stim_r(mode, k % 2048));
            in_i     = IN_W'((s0 + k / 2048) << 11);
            enable   = !(k == pause_k && pause_left > 0);
            #1;
            if (!enable) begin
                if (pause_left == 6)
                    check("ready_while_disabled", in_ready, 0);
                pause_left--;
            end else if (in_ready) begin
                k++;
            end else begin
                stalls++;
            end
        end
        check($sformatf("wr_complete_s%0d", s0), k, total);
        @(negedge clk);
        in_valid = 1'b0;
        enable   = 1'b1;
    endtask

    task automatic chk_sym(input int s, input int sidx, input int mode, input bit gapless);
        int cp;
        int n;
        int idx;
        int waited = 0;
        int errs   = 0;
        cp = (sidx == 0 || sidx == 7) ? 160 : 144;
        n  = cp + 2048;
        @(negedge clk);
        while (!out_valid && waited < 12000) begin
            @(negedge clk);
            waited++;
        end
        if (gapless)
            check($sformatf("sym%0d_gap", s), waited, 0);
        else
            check($sformatf("sym%0d_arrive", s), out_valid, 1);
        for (int j = 0; j < n; j++) begin
            if (j > 0)
                @(negedge clk);
            idx = (j < cp) ? 2048 - cp + j : j - cp;
            if (out_valid !== 1'b1) errs++;
            if (int'(out_r) != want_r(mode, idx)) errs++;
            if (int'(out_i) != s) errs++;
            if (sym_start !== (j == 0)) errs++;
            if (slot_done !== (j == n - 1 && sidx == 13)) errs++;
            if (slot_done) slot_done_seen++;
            if (mode == 1 && j >= cp && j < cp + 5)
                rnd_obs[j - cp] = int'(out_r);
        end
        check($sformatf("sym%0d_samples", s), errs, 0);
    endtask

    initial begin
        int stall;
        int waited;
        int idle_valid;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_i", out_i, 0);
        check("rst_sym_start", sym_start, 0);
        check("rst_slot_done", slot_done, 0);
        check("rst_in_ready_disabled", in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        #1;
        check("in_ready_enabled", in_ready, 1);

        // Three continuous symbols: long then short CP, bank-full stall, gapless output
        fork
            wr_syms(0, 3, 0, -1, stall);
            begin
                chk_sym(0, 0, 0, 1'b0);
                chk_sym(1, 1, 0, 1'b1);
                chk_sym(2, 2, 0, 1'b1);
            end
        join
        check("stall_cycles", stall, 161);

        // Rounding/saturation symbol with an enable gap mid-write
        fork
            wr_syms(3, 1, 1, 1000, stall);
            chk_sym(3, 3, 1, 1'b0);
        join
        check("round_1023", rnd_obs[0], 0);
        check("round_1024", rnd_obs[1], 1);
        check("round_m1025", rnd_obs[2], -1);
        check("sat_pos", rnd_obs[3], 16383);
        check("sat_neg", rnd_obs[4], -16384);

        // Rest of the slot and the first symbol of the next slot
        fork
            wr_syms(4, 11, 0, -1, stall);
            begin
                for (int s = 4; s < 15; s++)
                    chk_sym(s, s % 14, 0, s != 4);
            end
        join
        check("slot_done_pulses", slot_done_seen, 1);

        // Reset during the body of a symbol
        wr_syms(15, 1, 0, -1, stall);
        waited = 0;
        while (!out_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("sym15_arrive", out_valid, 1);
        check("sym15_first", out_r, 1904);
        check("sym15_start", sym_start, 1);
        repeat (600) @(negedge clk);
        check("pre_reset_valid", out_valid, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_r", out_r, 0);
        check("midrst_out_i", out_i, 0);
        check("midrst_in_ready", in_ready, 1);
        idle_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) idle_valid++;
        end
        check("idle_after_reset", idle_valid, 0);
        fork
            wr_syms(16, 1, 0, -1, stall);
            chk_sym(16, 0, 0, 1'b0);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
